// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder: funct3 widths, FSM states,
// default base address and the store byte-lane mask helper.
package mem_pkg;

  localparam logic [31:0] MEM_BASE = 32'h8000_0000;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Byte lanes touched by a store of the given width at the given byte offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3)
      F3_B:    m = 4'b0001 << off;
      F3_H:    m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_mem_responder_byte_lane_ram.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// Read data appears the cycle after re_i; it holds until the next read.
module byte_lane_ram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk_i,
  input  logic [3:0]                     we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr_i,
  input  logic [31:0]                    wdata_i,
  input  logic                           re_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem[raddr_i];
    end
  end

  // Storage is deliberately unreset; contents survive a core reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one outstanding request, LATENCY cycles in BUSY, then a held response.
// Response valid LATENCY edges after acceptance; rsp held stable while rsp_ready_i=0, no new request until consumed.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = MEM_BASE,
  parameter int          LATENCY     = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_funct3_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam int          CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        accept;
  logic        commit;
  logic        in_range;
  logic        misalign;
  logic        legal_f3;
  logic        acc_err;
  logic [31:0] ram_rdata;
  logic [31:0] lane_word;
  logic [31:0] load_data;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;

  // Fault classification on the latched request.
  always_comb begin
    in_range = ({1'b0, addr_q} >= {1'b0, BASE_ADDR}) && ({1'b0, addr_q} < END_ADDR);
    misalign = 1'b0;
    legal_f3 = 1'b0;
    case (f3_q)
      F3_B:  legal_f3 = 1'b1;
      F3_H:  begin legal_f3 = 1'b1;  misalign = addr_q[0];    end
      F3_W:  begin legal_f3 = 1'b1;  misalign = |addr_q[1:0]; end
      F3_BU: legal_f3 = !we_q;
      F3_HU: begin legal_f3 = !we_q; misalign = addr_q[0];    end
      default: legal_f3 = 1'b0;
    endcase
    acc_err = !in_range || misalign || !legal_f3;
  end

  always_comb begin
    lane_word = ram_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      F3_B:    load_data = {{24{lane_word[7]}}, lane_word[7:0]};
      F3_H:    load_data = {{16{lane_word[15]}}, lane_word[15:0]};
      F3_BU:   load_data = {24'd0, lane_word[7:0]};
      F3_HU:   load_data = {16'd0, lane_word[15:0]};
      default: load_data = ram_rdata;
    endcase
  end

  always_comb begin
    commit = (state_q == BUSY) && (cnt_q == '0);
    ram_we = (commit && we_q && !acc_err) ? lane_mask(f3_q, addr_q[1:0]) : 4'b0000;
    case (f3_q)
      F3_B:    ram_wdata = {4{wdata_q[7:0]}};
      F3_H:    ram_wdata = {2{wdata_q[15:0]}};
      default: ram_wdata = wdata_q;
    endcase
  end

  // Read is launched straight from the request bus at acceptance, so the
  // registered RAM output is already settled when BUSY expires.
  byte_lane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (AW'((addr_q - BASE_ADDR) >> 2)),
    .wdata_i (ram_wdata),
    .re_i    (accept && !req_we_i),
    .raddr_i (AW'((req_addr_i - BASE_ADDR) >> 2)),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    accept      = (state_q == IDLE) && req_valid_i && ready_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = CW'(LATENCY - 1);
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          f3_d    = req_funct3_i;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (acc_err || we_q) ? 32'd0 : load_data;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d     = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      f3_q        <= 3'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances (LATENCY 1, 3, 4) share stimulus,
// sel picks which one the current scenario observes.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_f3;
  logic        rsp_ready;

  logic        rdy1, rdy3, rdy4, vld1, vld3, vld4, err1, err3, err4;
  logic [31:0] rd1, rd3, rd4;
  logic        rdy, vld, err;
  logic [31:0] rdata;
  int          sel;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy1), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_funct3_i(req_f3), .rsp_valid_o(vld1),
    .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd1), .rsp_err_o(err1));

  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy3), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_funct3_i(req_f3), .rsp_valid_o(vld3),
    .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd3), .rsp_err_o(err3));

  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy4), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_funct3_i(req_f3), .rsp_valid_o(vld4),
    .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd4), .rsp_err_o(err4));

  always_comb begin
    case (sel)
      1:       begin rdy = rdy3; vld = vld3; rdata = rd3; err = err3; end
      2:       begin rdy = rdy4; vld = vld4; rdata = rd4; err = err4; end
      default: begin rdy = rdy1; vld = vld1; rdata = rd1; err = err1; end
    endcase
  end

  // One request/response through the selected instance; returns at the negedge
  // where the response is first seen (handshake happens on the following edge).
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [2:0] f3, output logic [31:0] rd, output logic e,
                      output int acc, output int lat);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_f3 = f3;
    guard = 0;
    while (rdy !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    acc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom_range(0, 1)); req_addr = $urandom();
    req_wdata = $urandom(); req_f3 = 3'($urandom_range(0, 7));
    while (vld !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    lat = cyc - acc;
    rd = rdata;
    e = err;
    if (guard >= 50) begin
      vectors++; miscompares++;
      $display("FAIL xact_timeout addr=%h guard=%0d required handshake within budget", addr, guard);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_f3 = 3'd0; rsp_ready = 1'b1; sel = 0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      vectors++;
      if ({rdy, vld, err, rdata} !== 35'd0) begin
        miscompares++;
        $display("FAIL reset_outputs inst=%0d rdy=%b vld=%b err=%b rdata=%h required all 0", s, rdy, vld, err, rdata);
      end
    end
    sel = 0;
    @(negedge clk); rst_n = 1'b1; #1;
    vectors++;
    if (rdy !== 1'b0) begin miscompares++; $display("FAIL ready_before_edge got=%b required 0", rdy); end
    @(negedge clk);
    vectors++;
    if (rdy !== 1'b1) begin miscompares++; $display("FAIL ready_after_edge got=%b required 1", rdy); end
  endtask

  task automatic test_sw_lw;
    logic [31:0] rd; logic e; int acc, lat;
    sel = 0;
    xact(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 3'd2, rd, e, acc, lat);
    vectors++;
    if ({rd, e, lat} !== {32'd0, 1'b0, 32'd1}) begin
      miscompares++; $display("FAIL sw_rsp rd=%h err=%b lat=%0d required 0/0/1", rd, e, lat);
    end
    xact(1'b0, 32'h8000_0010, 32'd0, 3'd2, rd, e, acc, lat);
    vectors++;
    if ({rd, e, lat} !== {32'hDEAD_BEEF, 1'b0, 32'd1}) begin
      miscompares++; $display("FAIL lw_rsp rd=%h err=%b lat=%0d required deadbeef/0/1", rd, e, lat);
    end
  endtask

  task automatic test_lanes;
    vec_t t [11];
    logic [31:0] rd; logic e; int acc, lat;
    sel = 0;
    t = '{'{1'b1, 32'h8000_0000, 32'h1122_3344, 3'd2, 32'h0000_0000, 1'b0},
          '{1'b1, 32'h8000_0002, 32'h1234_56A5, 3'd0, 32'h0000_0000, 1'b0},
          '{1'b0, 32'h8000_0000, 32'h0,         3'd2, 32'h11A5_3344, 1'b0},
          '{1'b0, 32'h8000_0002, 32'h0,         3'd0, 32'hFFFF_FFA5, 1'b0},
          '{1'b0, 32'h8000_0002, 32'h0,         3'd4, 32'h0000_00A5, 1'b0},
          '{1'b0, 32'h8000_0002, 32'h0,         3'd1, 32'h0000_11A5, 1'b0},
          '{1'b0, 32'h8000_0000, 32'h0,         3'd5, 32'h0000_3344, 1'b0},
          '{1'b1, 32'h8000_0000, 32'hDEAD_8001, 3'd1, 32'h0000_0000, 1'b0},
          '{1'b0, 32'h8000_0000, 32'h0,         3'd1, 32'hFFFF_8001, 1'b0},
          '{1'b0, 32'h8000_0000, 32'h0,         3'd2, 32'h11A5_8001, 1'b0},
          '{1'b0, 32'h8000_0001, 32'h0,         3'd0, 32'hFFFF_FF80, 1'b0}};
    for (int i = 0; i < 11; i++) begin
      xact(t[i].we, t[i].addr, t[i].wd, t[i].f3, rd, e, acc, lat);
      vectors++;
      if (rd !== t[i].rd || e !== t[i].er) begin
        miscompares++;
        $display("FAIL lanes[%0d] rd=%h err=%b required %h/%b", i, rd, e, t[i].rd, t[i].er);
      end
    end
  endtask

  task automatic test_faults;
    vec_t t [12];
    logic [31:0] rd; logic e; int acc, lat;
    sel = 0;
    t = '{'{1'b1, 32'h8000_0FFC, 32'h0BAD_F00D, 3'd2, 32'h0000_0000, 1'b0},
          '{1'b0, 32'h8000_0001, 32'h0,         3'd1, 32'h0000_0000, 1'b1},
          '{1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 3'd2, 32'h0000_0000, 1'b1},
          '{1'b0, 32'h8000_0FFC, 32'h0,         3'd2, 32'h0BAD_F00D, 1'b0},
          '{1'b0, 32'h8000_0000, 32'h0,         3'd3, 32'h0000_0000, 1'b1},
          '{1'b0, 32'h8000_1000, 32'h0,         3'd2, 32'h0000_0000, 1'b1},
          '{1'b1, 32'h8000_0FFE, 32'h0,         3'd2, 32'h0000_0000, 1'b1},
          '{1'b1, 32'h8000_0FFC, 32'h0,         3'd4, 32'h0000_0000, 1'b1},
          '{1'b1, 32'h8000_0FFD, 32'h0,         3'd1, 32'h0000_0000, 1'b1},
          '{1'b0, 32'h8000_0FFC, 32'h0,         3'd2, 32'h0BAD_F00D, 1'b0},
          '{1'b0, 32'h8000_0FFC, 32'h0,         3'd6, 32'h0000_0000, 1'b1},
          '{1'b0, 32'h8000_0FFF, 32'h0,         3'd0, 32'h0000_000B, 1'b0}};
    for (int i = 0; i < 12; i++) begin
      xact(t[i].we, t[i].addr, t[i].wd, t[i].f3, rd, e, acc, lat);
      vectors++;
      if (rd !== t[i].rd || e !== t[i].er) begin
        miscompares++;
        $display("FAIL faults[%0d] rd=%h err=%b required %h/%b", i, rd, e, t[i].rd, t[i].er);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic e; int acc, lat, guard, d;
    sel = 1;
    xact(1'b1, 32'h8000_0040, 32'h55AA_1234, 3'd2, rd, e, acc, lat);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0040; req_f3 = 3'd2;
    guard = 0;
    while (rdy !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    acc = cyc + 1;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      d = cyc - acc;
      if (d == 0) req_valid = 1'b0;
      if (d == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_0040; req_wdata = 32'hFFFF_FFFF; req_f3 = 3'd2;
      end
      if (d == 4) req_valid = 1'b0;
      vectors++;
      if (rdy !== 1'b0 || vld !== (d >= 3)) begin
        miscompares++; $display("FAIL bp_handshake d=%0d rdy=%b vld=%b required 0/%b", d, rdy, vld, d >= 3);
      end
      if (d >= 3) begin
        vectors++;
        if (rdata !== 32'h55AA_1234 || err !== 1'b0) begin
          miscompares++; $display("FAIL bp_hold d=%0d rd=%h err=%b required 55aa1234/0", d, rdata, err);
        end
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (vld !== 1'b0 || rdy !== 1'b1) begin
      miscompares++; $display("FAIL bp_release vld=%b rdy=%b required 0/1", vld, rdy);
    end
    xact(1'b0, 32'h8000_0040, 32'd0, 3'd2, rd, e, acc, lat);
    vectors++;
    if (rd !== 32'h55AA_1234) begin
      miscompares++; $display("FAIL bp_pulse_ignored rd=%h required 55aa1234", rd);
    end
  endtask

  task automatic test_reset_mid_store;
    logic [31:0] rd; logic e; int acc, lat, guard;
    sel = 2;
    xact(1'b1, 32'h8000_0020, 32'h1357_9BDF, 3'd2, rd, e, acc, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'hCAFE_F00D; req_f3 = 3'd2;
    guard = 0;
    while (rdy !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; #1;
    vectors++;
    if ({rdy, vld, err, rdata} !== 35'd0) begin
      miscompares++;
      $display("FAIL midrst_outputs rdy=%b vld=%b err=%b rd=%h required all 0", rdy, vld, err, rdata);
    end
    @(negedge clk); rst_n = 1'b1;
    xact(1'b0, 32'h8000_0020, 32'd0, 3'd2, rd, e, acc, lat);
    vectors++;
    if (rd !== 32'h1357_9BDF || e !== 1'b0) begin
      miscompares++; $display("FAIL midrst_prior rd=%h err=%b required 13579bdf/0", rd, e);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  refm [logic [31:0]];
    logic [31:0] rd, a, v, expv; logic e; int acc, lat, prev;
    sel = 1;
    rsp_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      a = 32'h8000_0200 + 32'(4 * (i / 2));
      if (i % 2 == 0) begin
        v = $urandom();
        for (int b = 0; b < 4; b++) refm[a + 32'(b)] = v[8*b +: 8];
        xact(1'b1, a, v, 3'd2, rd, e, acc, lat);
      end else begin
        expv = {refm[a + 32'd3], refm[a + 32'd2], refm[a + 32'd1], refm[a]};
        xact(1'b0, a, 32'd0, 3'd2, rd, e, acc, lat);
        vectors++;
        if (rd !== expv || e !== 1'b0) begin
          miscompares++; $display("FAIL b2b_data[%0d] rd=%h err=%b required %h/0", i, rd, e, expv);
        end
      end
      if (i > 0) begin
        vectors++;
        if (acc - prev !== 5) begin
          miscompares++; $display("FAIL b2b_spacing[%0d] got=%0d required 5", i, acc - prev);
        end
      end
      prev = acc;
    end
  endtask

  initial begin
    test_reset;
    test_sw_lw;
    test_lanes;
    test_faults;
    test_backpressure;
    test_reset_mid_store;
    test_back_to_back;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's load/store port. It accepts one request at a time over a valid/ready handshake and decodes the RISC-V load/store width from funct3. Storage is byte-lane little-endian with a programmable wait latency. It returns read data, sign- or zero-extended, on a separate valid/ready response channel. It sits between the core's data-memory interface and on-chip RAM, and replaces the single-cycle combinational memory model once the core becomes a multi-cycle FSM.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored (power of two).
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- LATENCY, 1: cycles spent in BUSY per request (≥1).

Ports (one clock; reset asynchronous, active-low):
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- req_funct3_i  in  3  RISC-V load/store funct3.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  requester takes the response.
- rsp_rdata_o  out  32  load result, extended; 0 for stores and errors.
- rsp_err_o  out  1  access fault or misalignment.

## Operation
- The FSM has three states: IDLE, BUSY and RESP.
- **IDLE:**
  - req_ready_o=1.
  - On req_valid_i&&req_ready_o, latch we/addr/wdata/funct3 and load wait counter = LATENCY-1.
  - Next state is BUSY.
- **BUSY:**
  - req_ready_o=0.
  - Counter decrements each cycle.
  - At counter==0 the access is performed, then the state moves to RESP.
- **RESP:**
  - rsp_valid_o=1, with rsp_rdata_o and rsp_err_o stable.
  - On rsp_valid_o&&rsp_ready_i, the state moves to IDLE and rsp_valid_o drops.
- Only one transaction is outstanding at a time. Requests are never accepted outside IDLE.
- Width decode:
  - Loads: 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU.
  - Stores: 0=SB, 1=SH, 2=SW.
  - Any other funct3 is an error.
- Lane selection: byte offset = addr[1:0]; word index = (addr-BASE_ADDR)>>2.
- Stores write only the addressed lanes: SB writes 1 lane, SH writes 2, SW writes 4. Unaddressed lanes are unchanged.
- Loads:
  - LB/LH sign-extend from bit 7 / bit 15 of the selected lane(s).
  - LBU/LHU zero-extend.
- Error conditions (rsp_err_o=1, rsp_rdata_o=0, no write):
  - addr < BASE_ADDR, or addr ≥ BASE_ADDR+4·DEPTH_WORDS;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - illegal funct3.
- Memory contents are not reset.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - req_ready_o=0, then 1 from the first clock edge after rst_ni deasserts.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
- All outputs are registered.
- Request accepted at edge N → rsp_valid_o high after edge N+LATENCY.
- The RAM read is synchronous and completes within the final BUSY cycle.
- Response consumed at edge M → req_ready_o=1 after edge M, so the earliest next acceptance is edge M+1.
- Peak throughput is one transaction per LATENCY+2 cycles.
- Backpressure: rsp_valid_o held indefinitely with data and error unchanged while rsp_ready_i=0.
- Request inputs are ignored outside IDLE and need not be held after acceptance.
- Reset asserted mid-transaction:
  - Immediate return to IDLE values.
  - A store that has not reached BUSY expiry is dropped; RAM is untouched.
  - A store already committed stays written.
- Store→load of the same address in consecutive transactions returns the new data (no bypass needed, since commit precedes response).

## Structure
- Package mem_pkg holds:
  - the funct3 localparams (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5);
  - the state enum {IDLE, BUSY, RESP};
  - MEM_BASE default 32'h8000_0000.
- Sub-module byte_lane_ram: DEPTH_WORDS×32 array, 4 byte write enables, registered read port.
- Decode, extension and FSM stay in data_mem_responder.

## Test plan
- **Reset then SW/LW**, LATENCY=1: SW 0x8000_0010 ← 0xDEAD_BEEF; LW same address → rdata 0xDEAD_BEEF, err 0, rsp_valid_o one cycle after acceptance.
- **Byte lanes and extension:** SW 0x8000_0000 ← 0x1122_3344; SB 0x8000_0002 ← 0xA5; LW → 0x11A5_3344; LB 0x8000_0002 → 0xFFFF_FFA5; LBU → 0x0000_00A5; LH 0x8000_0002 → 0x0000_11A5.
- **Faults:** LH 0x8000_0001 → err 1, rdata 0; SW 0x7FFF_FFFC → err 1 and RAM unchanged; funct3=3 load → err 1; LW at BASE+4·DEPTH_WORDS → err 1.
- **Backpressure:** LATENCY=3, hold rsp_ready_i=0 for 10 cycles → rsp_valid_o asserted 3 cycles after acceptance and stable; req_ready_o=0 throughout; a req_valid_i pulse meanwhile is not accepted.
- **Reset mid-store:** LATENCY=4, SW 0x8000_0020 ← 0xCAFE_F00D, then assert rst_ni=0 two cycles later → outputs at reset values immediately; subsequent LW returns the prior contents.
- **Back-to-back:** 8 alternating SW/LW with rsp_ready_i tied 1 → each acceptance exactly LATENCY+2 cycles apart; all read data matches a byte-accurate reference model.
